// File: rtl/fifo_128to16_sync.sv
// fifo_128to16_sync: single-clock FIFO taking 128-bit words and delivering 16-bit halfwords FWFT, LS halfword first.
module fifo_128to16_sync #(
    parameter int WR_DEPTH_WIDTH   = 8,
    parameter int ALMOST_FULL_NUM  = 252,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int RD_DEPTH_WIDTH   = WR_DEPTH_WIDTH + 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [127:0]              wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    input  logic                      rd_en,
    output logic [15:0]               rd_data,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level
);
    localparam int DEPTH_N = 1 << WR_DEPTH_WIDTH;
    localparam logic [WR_DEPTH_WIDTH:0] DEPTH = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
    localparam logic [WR_DEPTH_WIDTH:0] AF = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
    localparam logic [RD_DEPTH_WIDTH:0] AE = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];

    logic [127:0]              mem [DEPTH_N];
    logic [WR_DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [2:0]                sub_idx;
    logic [WR_DEPTH_WIDTH:0]   word_cnt;
    logic                      wr_acc, rd_acc, free;

    assign wr_full        = word_cnt == DEPTH;
    assign rd_empty       = word_cnt == '0;
    assign wr_acc         = wr_en & ~wr_full;
    assign rd_acc         = rd_en & ~rd_empty;
    assign free           = rd_acc & (sub_idx == 3'd7);
    assign wr_water_level = word_cnt;
    assign rd_water_level = {word_cnt, 3'b000} - {{(WR_DEPTH_WIDTH+1){1'b0}}, sub_idx};
    assign almost_full    = wr_water_level >= AF;
    assign almost_empty   = rd_water_level <= AE;
    assign rd_data        = rd_empty ? 16'h0 : mem[rd_ptr][{sub_idx, 4'b0000} +: 16];

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sub_idx  <= '0;
            word_cnt <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) sub_idx <= sub_idx + 3'd1;
            if (free) rd_ptr <= rd_ptr + 1'b1;
            word_cnt <= (wr_acc && !free) ? word_cnt + 1'b1 :
                        (!wr_acc && free) ? word_cnt - 1'b1 : word_cnt;
        end
    end
endmodule

// File: tb/tb_fifo_128to16_sync.sv
// tb_fifo_128to16_sync: directed self-checking bench for the 128-to-16 FWFT FIFO.
module tb_fifo_128to16_sync;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [127:0] wr_data = '0;
    logic         rd_en = 1'b0;
    logic         wr_full, almost_full, rd_empty, almost_empty;
    logic [8:0]   wr_water_level;
    logic [11:0]  rd_water_level;
    logic [15:0]  rd_data;
    int           checks = 0;
    int           errors = 0;

    fifo_128to16_sync dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .almost_full(almost_full), .wr_water_level(wr_water_level),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .almost_empty(almost_empty), .rd_water_level(rd_water_level)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mkword(int k);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(k * 8 + j);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty"}, rd_empty, 1'b1);
        chk({tag, "_ae"}, almost_empty, 1'b1);
        chk({tag, "_full"}, wr_full, 1'b0);
        chk({tag, "_af"}, almost_full, 1'b0);
        chk({tag, "_wlvl"}, wr_water_level, 0);
        chk({tag, "_rlvl"}, rd_water_level, 0);
        chk({tag, "_data"}, rd_data, 0);
    endtask

    initial begin
        int wc, rc, cyc;
        #1;
        chk_reset("rst");
        step();
        step();
        rst_n = 1'b1;

        // single word, read out 8 halfwords
        wr_en = 1'b1;
        wr_data = mkword(0);
        step();
        wr_en = 1'b0;
        chk("sw_empty", rd_empty, 1'b0);
        chk("sw_wlvl", wr_water_level, 1);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("sw_data", rd_data, i);
            chk("sw_rlvl", rd_water_level, 8 - i);
            chk("sw_ae", almost_empty, (8 - i) <= 4);
            step();
        end
        rd_en = 1'b0;
        chk("sw_empty_end", rd_empty, 1'b1);
        chk("sw_rlvl_end", rd_water_level, 0);

        // fill to full
        wr_en = 1'b1;
        for (int k = 0; k < 256; k++) begin
            wr_data = mkword(k);
            step();
            chk("fill_wlvl", wr_water_level, k + 1);
            chk("fill_af", almost_full, (k + 1) >= 252);
            chk("fill_full", wr_full, (k + 1) == 256);
        end
        wr_data = {8{16'hDEAD}};
        step();
        wr_en = 1'b0;
        chk("ovf_wlvl", wr_water_level, 256);
        chk("ovf_full", wr_full, 1'b1);

        // readback; write while full during the word-freeing read is dropped
        rd_en = 1'b1;
        for (int i = 0; i < 2056; i++) begin
            wr_en = (i == 7) || (i == 8);
            wr_data = (i == 7) ? {8{16'hBEEF}} : mkword(256);
            chk("rb_data", rd_data, 16'(i));
            step();
            if (i == 7) chk("fs_wlvl_255", wr_water_level, 255);
            if (i == 8) chk("fs_wlvl_256", wr_water_level, 256);
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("rb_empty", rd_empty, 1'b1);

        // wrap-around streaming: writes every 8th cycle, reads every cycle
        wc = 0;
        rc = 0;
        cyc = 0;
        rd_en = 1'b1;
        while (rc < 4096 && cyc < 5000) begin
            wr_en = (cyc % 8 == 0) && (wc < 512);
            wr_data = mkword(wc);
            chk("st_empty", rd_empty, (wc * 8) == rc);
            if (wc * 8 != rc) chk("st_data", rd_data, 16'(rc));
            chk("st_rlvl", rd_water_level, wc * 8 - rc);
            chk("st_lvl_max", rd_water_level <= 12'd2048, 1'b1);
            step();
            if (wc * 8 != rc) rc++;
            if (wr_en) wc++;
            cyc++;
        end
        chk("st_done", rc, 4096);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("st_empty_end", rd_empty, 1'b1);

        // empty with simultaneous read and write
        rd_en = 1'b1;
        wr_en = 1'b1;
        wr_data = mkword(600);
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("es_rlvl", rd_water_level, 8);
        chk("es_data", rd_data, 16'd4800);
        chk("es_ae", almost_empty, 1'b0);
        rd_en = 1'b1;
        step();
        step();
        step();
        rd_en = 1'b0;
        chk("es_rlvl5", rd_water_level, 5);
        chk("es_ae5", almost_empty, 1'b0);
        chk("es_data3", rd_data, 16'd4803);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("es_rlvl4", rd_water_level, 4);
        chk("es_ae4", almost_empty, 1'b1);

        // mid-operation reset
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rd_en = 1'b0;
        wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_data = mkword(700 + k);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd_en = 1'b0;
        chk("mr_rlvl_pre", rd_water_level, 19);
        rst_n = 1'b0;
        #1;
        chk_reset("mr");
        step();
        step();
        rst_n = 1'b1;
        wr_en = 1'b1;
        wr_data = mkword(900);
        step();
        wr_en = 1'b0;
        chk("mr_data0", rd_data, 16'd7200);
        chk("mr_rlvl", rd_water_level, 8);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("mr_data1", rd_data, 16'd7201);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
